// File: rtl/bomb_controller_if.sv
// bomb_controller_if: player/VGA inputs and bomb/blast outputs of bomb_controller.
interface bomb_controller_if;
    logic       place_btn;
    logic [9:0] b_x, b_y, v_x, v_y;
    logic [9:0] e_x, e_y;
    logic       explosion_SCEN, bomb_active, blast_active, bomb_on, blast_on;
    modport master (
        output place_btn, b_x, b_y, v_x, v_y,
        input  e_x, e_y, explosion_SCEN, bomb_active, blast_active, bomb_on, blast_on
    );
    modport slave (
        input  place_btn, b_x, b_y, v_x, v_y,
        output e_x, e_y, explosion_SCEN, bomb_active, blast_active, bomb_on, blast_on
    );
endinterface

// File: rtl/bomb_controller.sv
// bomb_controller: grid-snapped bomb placement, fuse/blast timers and pixel hit decode.
module bomb_controller #(
    parameter int FUSE_CYCLES  = 100_000_000,
    parameter int BLAST_CYCLES = 50_000_000,
    parameter int CNT_W        = 28
) (
    input logic clk,
    input logic reset,
    bomb_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FUSE, BLAST} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       ex_q, ex_d, ey_q, ey_d;
    logic             btn_q, scen_q, scen_d, bomb_on_q, bomb_on_d, blast_on_q, blast_on_d;
    logic [10:0]      sx, sy, vx, vy, ex, ey;
    logic             req, tile_x, tile_y, arm_x, arm_y;
    always_comb begin
        req        = bus.place_btn & ~btn_q;
        sx         = {1'b0, bus.b_x} + 11'd8;
        sy         = {1'b0, bus.b_y} + 11'd8;
        vx         = {1'b0, bus.v_x};
        vy         = {1'b0, bus.v_y};
        ex         = {1'b0, ex_q};
        ey         = {1'b0, ey_q};
        // Lower bounds add 48 to the pixel so arms clip at the screen edge instead of wrapping.
        tile_x     = vx >= ex && vx <= ex + 11'd15;
        tile_y     = vy >= ey && vy <= ey + 11'd15;
        arm_x      = vx + 11'd48 >= ex && vx <= ex + 11'd63;
        arm_y      = vy + 11'd48 >= ey && vy <= ey + 11'd63;
        bomb_on_d  = state_q == FUSE && tile_x && tile_y;
        blast_on_d = state_q == BLAST && ((arm_x && tile_y) || (arm_y && tile_x));
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        ex_d       = ex_q;
        ey_d       = ey_q;
        scen_d     = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (req) begin
                state_d = FUSE;
                ex_d    = sx[9:0] & 10'h3F0;
                ey_d    = sy[9:0] & 10'h3F0;
            end
        end else if (state_q == FUSE && cnt_q == CNT_W'(FUSE_CYCLES - 1)) begin
            state_d = BLAST;
            cnt_d   = '0;
            scen_d  = 1'b1;
        end else if (state_q == BLAST && cnt_q == CNT_W'(BLAST_CYCLES - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            btn_q      <= 1'b0;
            ex_q       <= '0;
            ey_q       <= '0;
            scen_q     <= 1'b0;
            bomb_on_q  <= 1'b0;
            blast_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_q      <= bus.place_btn;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            scen_q     <= scen_d;
            bomb_on_q  <= bomb_on_d;
            blast_on_q <= blast_on_d;
        end
    end
    assign bus.e_x            = ex_q;
    assign bus.e_y            = ey_q;
    assign bus.explosion_SCEN = scen_q;
    assign bus.bomb_active    = state_q == FUSE;
    assign bus.blast_active   = state_q == BLAST;
    assign bus.bomb_on        = bomb_on_q;
    assign bus.blast_on       = blast_on_q;
endmodule

// File: tb/tb_bomb_controller.sv
// tb_bomb_controller: timeline model of placement/fuse/blast checked every cycle, plus directed literals.
module tb_bomb_controller;
    localparam int F = 10;
    localparam int B = 5;
    logic clk = 1'b0;
    logic reset = 1'b1;
    bomb_controller_if bus();
    bomb_controller #(.FUSE_CYCLES(F), .BLAST_CYCLES(B), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int n_bomb = 0, n_scen = 0, n_blast = 0;
    int cyc = 0, armed_at = -1000, mex = 0, mey = 0;
    bit prev = 1'b0;
    bit exp_scen = 0, exp_bomb = 0, exp_blast = 0, exp_bon = 0, exp_blon = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit inr(input int v, input int e, input int lo, input int hi);
        return v >= e + lo && v <= e + hi;
    endfunction

    // Model: phase is derived from how many edges have passed since the accepted press.
    initial forever begin
        int d0, d;
        bit fuse0, blast0;
        @(posedge clk or negedge reset);
        if (!reset) begin
            cyc = 0; armed_at = -1000; prev = 0; mex = 0; mey = 0;
            exp_scen = 0; exp_bomb = 0; exp_blast = 0; exp_bon = 0; exp_blon = 0;
        end else begin
            d0 = cyc - 1 - armed_at;
            fuse0 = d0 >= 0 && d0 < F;
            blast0 = d0 >= F && d0 < F + B;
            exp_bon = fuse0 && inr(int'(bus.v_x), mex, 0, 15) && inr(int'(bus.v_y), mey, 0, 15);
            exp_blon = blast0 && ((inr(int'(bus.v_x), mex, -48, 63) && inr(int'(bus.v_y), mey, 0, 15)) ||
                                  (inr(int'(bus.v_y), mey, -48, 63) && inr(int'(bus.v_x), mex, 0, 15)));
            if (!fuse0 && !blast0 && bus.place_btn && !prev) begin
                armed_at = cyc;
                mex = ((int'(bus.b_x) + 8) % 1024) / 16 * 16;
                mey = ((int'(bus.b_y) + 8) % 1024) / 16 * 16;
            end
            prev = bus.place_btn;
            d = cyc - armed_at;
            exp_bomb = d >= 0 && d < F;
            exp_blast = d >= F && d < F + B;
            exp_scen = d == F;
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("e_x", 32'(bus.e_x), 32'(mex));
        chk("e_y", 32'(bus.e_y), 32'(mey));
        chk("explosion_SCEN", 32'(bus.explosion_SCEN), 32'(exp_scen));
        chk("bomb_active", 32'(bus.bomb_active), 32'(exp_bomb));
        chk("blast_active", 32'(bus.blast_active), 32'(exp_blast));
        chk("bomb_on", 32'(bus.bomb_on), 32'(exp_bon));
        chk("blast_on", 32'(bus.blast_on), 32'(exp_blon));
        if (reset) begin
            n_bomb += int'(bus.bomb_active);
            n_scen += int'(bus.explosion_SCEN);
            n_blast += int'(bus.blast_active);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int bx, input int by);
        bus.b_x = 10'(bx);
        bus.b_y = 10'(by);
        bus.place_btn = 1'b1;
        step();
        bus.place_btn = 1'b0;
    endtask

    int pts [9][5] = '{
        '{160, 160, 112, 165, 1}, '{160, 160, 111, 165, 0}, '{160, 160, 223, 170, 1},
        '{160, 160, 224, 170, 0}, '{160, 160, 165, 112, 1}, '{160, 160, 176, 176, 0},
        '{16, 0, 0, 5, 1}, '{16, 0, 1000, 5, 0}, '{16, 0, 20, 1020, 0}
    };

    initial begin
        int sb, ss, sl;
        bus.place_btn = 0; bus.b_x = 0; bus.b_y = 0; bus.v_x = 0; bus.v_y = 0;
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("reset e_x", 32'(bus.e_x), 0);
        chk("reset bomb_active", 32'(bus.bomb_active), 0);
        sb = n_bomb; ss = n_scen; sl = n_blast;
        press(169, 71);
        chk("snap e_x", 32'(bus.e_x), 176);
        chk("snap e_y", 32'(bus.e_y), 64);
        chk("armed", 32'(bus.bomb_active), 1);
        bus.v_x = 176; bus.v_y = 64; step();
        chk("bomb px 176,64", 32'(bus.bomb_on), 1);
        bus.v_x = 191; bus.v_y = 79; step();
        chk("bomb px 191,79", 32'(bus.bomb_on), 1);
        bus.v_x = 192; bus.v_y = 64; step();
        chk("bomb px 192,64", 32'(bus.bomb_on), 0);
        press(500, 500);
        repeat (6) step();
        bus.v_x = 176; bus.v_y = 64; step();
        chk("in blast", 32'(bus.blast_active), 1);
        step();
        chk("bomb px in blast", 32'(bus.bomb_on), 0);
        bus.b_x = 600; bus.place_btn = 1'b1;
        repeat (20) step();
        chk("fuse cycles", 32'(n_bomb - sb), 10);
        chk("scen pulses", 32'(n_scen - ss), 1);
        chk("blast cycles", 32'(n_blast - sl), 5);
        chk("held stays idle", 32'(bus.bomb_active), 0);
        chk("ignored e_x", 32'(bus.e_x), 176);
        bus.place_btn = 1'b0;
        step();
        foreach (pts[i]) begin
            press(pts[i][0], pts[i][1]);
            repeat (10) step();
            chk("scen with blast", 32'(bus.explosion_SCEN & bus.blast_active), 1);
            bus.v_x = 10'(pts[i][2]); bus.v_y = 10'(pts[i][3]);
            step();
            chk($sformatf("blast px %0d,%0d", pts[i][2], pts[i][3]), 32'(bus.blast_on), 32'(pts[i][4]));
            repeat (6) step();
        end
        press(169, 71);
        repeat (6) step();
        ss = n_scen;
        reset = 1'b0;
        #1;
        chk("abort bomb_active", 32'(bus.bomb_active), 0);
        chk("abort e_x", 32'(bus.e_x), 0);
        chk("abort scen", 32'(bus.explosion_SCEN), 0);
        step();
        reset = 1'b1;
        repeat (20) step();
        chk("no scen after abort", 32'(n_scen - ss), 0);
        press(169, 71);
        chk("rearm e_x", 32'(bus.e_x), 176);
        chk("rearm active", 32'(bus.bomb_active), 1);
        repeat (20) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bomb_controller.md
# bomb_controller

Upstream stage for the box and explosion logic. It takes a place-bomb request from the player and snaps the bomb to the 16×16 tile grid under Bomberman. It then runs the fuse and blast timers and produces the explosion location plus a single-cycle explosion pulse, which box_top consumes as `e_x`, `e_y` and `explosion_SCEN`. It also reports per-pixel hits for the bomb sprite and the plus-shaped blast, so the top-level renderer can colour them.

## Interface
Parameters:
- `FUSE_CYCLES`, default 100_000_000: cycles the bomb stays armed before detonating; minimum 2.
- `BLAST_CYCLES`, default 50_000_000: cycles the blast stays displayed; minimum 1.
- `CNT_W`, default 28: timer counter width; must hold max(FUSE_CYCLES, BLAST_CYCLES).

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `place_btn`  in  1  debounced, level-high place request; synchronous to `clk`.
- `b_x`, `b_y`  in  10  Bomberman top-left pixel.
- `v_x`, `v_y`  in  10  current VGA pixel.
- `e_x`, `e_y`  out  10  grid-snapped bomb/explosion top-left pixel.
- `explosion_SCEN`  out  1  one-cycle detonation pulse.
- `bomb_active`  out  1  high while the fuse is running.
- `blast_active`  out  1  high while the blast is displayed.
- `bomb_on`  out  1  current pixel is inside the armed bomb tile.
- `blast_on`  out  1  current pixel is inside the blast plus shape.

## Operation
- State machine has three states: IDLE → FUSE → BLAST → IDLE.
- Request detection:
  - `place_btn` is registered each cycle.
  - A request is a rising edge: current high, previous low.
- IDLE:
  - On a request, latch `e_x = (b_x + 8) & 10'h3F0` and `e_y = (b_y + 8) & 10'h3F0`.
  - The sum is computed 11 bits wide, then truncated to 10 bits.
  - Clear the counter and go to FUSE.
- FUSE:
  - The counter increments every cycle.
  - When the counter equals FUSE_CYCLES−1, clear it, go to BLAST and assert `explosion_SCEN`.
  - Requests are ignored.
- BLAST:
  - The counter increments every cycle.
  - When the counter equals BLAST_CYCLES−1, clear it and go to IDLE.
  - Requests are ignored.
- Output decode:
  - `bomb_active` = (state==FUSE).
  - `blast_active` = (state==BLAST).
  - `e_x` and `e_y` hold their value until the next placement.
- `bomb_on`: `bomb_active` and v_x∈[e_x, e_x+15] and v_y∈[e_y, e_y+15].
- `blast_on`: `blast_active` and (horizontal arm or vertical arm).
  - Horizontal arm: v_x∈[e_x−48, e_x+63] and v_y∈[e_y, e_y+15].
  - Vertical arm: v_y∈[e_y−48, e_y+63] and v_x∈[e_x, e_x+15].
  - This matches box_top's explosion extents: 3 tiles each side plus the centre.
- Arithmetic rules:
  - All compares are 11 bits wide, with no wrap-around.
  - Lower bounds are written as `v + 48 >= e`, never `v >= e − 48`. An arm near the screen edge (e_x<48 or e_y<48) is therefore clipped, not wrapped.
  - Upper bounds use 11-bit sums.

## Timing
- Reset values:
  - State is IDLE; counter and registered `place_btn` are 0.
  - `e_x` = `e_y` = 0.
  - `explosion_SCEN`, `bomb_active`, `blast_active`, `bomb_on` and `blast_on` are all 0.
- Reset is asynchronous:
  - Asserting it mid-FUSE or mid-BLAST aborts immediately.
  - No `explosion_SCEN` is emitted.
  - Registered `place_btn` resets to 0, so a button held through reset release is seen as an edge on the first sampled cycle.
- Placement timing: if the request edge is sampled at edge n, then `bomb_active`=1 and `e_x`/`e_y` are valid from edge n+1.
- Fuse and pulse timing:
  - FUSE lasts exactly FUSE_CYCLES cycles.
  - `explosion_SCEN` is high for exactly the first cycle of BLAST, with `blast_active` already 1.
  - `e_x`/`e_y` are stable in that cycle.
- BLAST lasts exactly BLAST_CYCLES cycles. IDLE then lasts at least 1 cycle before the next FUSE.
- Button held across states: a press held from FUSE through the return to IDLE does not re-arm; a new rising edge is required.
- `bomb_on`/`blast_on` are registered: a one-cycle latency from `v_x`/`v_y`.

## Test plan
All scenarios use FUSE_CYCLES=10, BLAST_CYCLES=5.
- Placement snap: b=(169,71), press → e=(176,64) one cycle later; `bomb_active`=1 for exactly 10 cycles; `explosion_SCEN` high for 1 cycle; `blast_active` high for 5 cycles; then IDLE.
- Ignored presses: a second rising edge during FUSE and another during BLAST → no change to `e_x`/`e_y` and no extra `explosion_SCEN`. A button held high after return to IDLE → stays IDLE.
- Blast shape at e=(160,160): v=(112,165) on, (111,165) off, (223,170) on, (224,170) off, (165,112) on, (176,176) off.
- Edge clip at e=(16,0): v=(0,5) on; v=(1000,5) off; vertical arm v=(20,1020) off.
- Reset mid-FUSE at count 6 → all outputs 0 immediately; no `explosion_SCEN` ever follows; a new press works normally.
- Bomb pixel: during FUSE with e=(176,64), v=(176,64) and (191,79) → `bomb_on`=1 one cycle later; (192,64) → 0; `bomb_on` is 0 during BLAST.
